// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and ring sizing helper for the K=7 Viterbi controller.
package viterbi_pkg;

    localparam int K            = 7;
    localparam int NUM_STATES   = 1 << (K - 1);
    localparam int TB_DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACS,
        S_CHK,
        S_TB
    } state_t;

    // Survivor ring holds two traceback blocks: one being written, one being traced.
    function automatic int ring_aw(input int tb_depth);
        return $clog2(2 * tb_depth);
    endfunction

endpackage

// File: rtl/viterbi_ctrl.sv
// Viterbi sequencer: accepts symbol pairs, strobes ACS, writes survivors, runs traceback per block.
// Latency: 3 cycles per symbol plus traceback wait; all outputs registered except in_ready.
// Backpressure: in_ready only in S_IDLE; optional VITERBI_NORM_CNT_EN adds norm_cnt.
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEF,
    parameter int AW       = ring_aw(TB_DEPTH),
    parameter int CW       = $clog2(TB_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_rx_pair,
    input  logic          in_last,
    output logic [1:0]    bmc_rx_pair,
    output logic          acs_en,
    output logic          acs_first,
    input  logic          pm_msb_any,
    output logic          pm_norm,
    output logic          surv_wr_en,
    output logic [AW-1:0] surv_wr_addr,
    output logic          tb_start,
    output logic [AW-1:0] tb_addr,
    output logic [CW-1:0] tb_len,
    input  logic          tb_done,
    output logic          frame_done
`ifdef VITERBI_NORM_CNT_EN
    ,
    output logic [15:0]   norm_cnt
`endif
);

    localparam logic [CW-1:0] BLOCK_LEN = CW'(TB_DEPTH);

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [CW-1:0] sym_cnt;
    logic [CW-1:0] sym_cnt_nxt;
    logic [CW-1:0] sym_inc;
    logic          first_flag;
    logic          first_flag_nxt;
    logic          last_q;
    logic          last_nxt;

    logic [1:0]    bmc_nxt;
    logic          acs_en_nxt;
    logic          acs_first_nxt;
    logic          pm_norm_nxt;
    logic          surv_wr_en_nxt;
    logic [AW-1:0] surv_addr_nxt;
    logic          tb_start_nxt;
    logic [AW-1:0] tb_addr_nxt;
    logic [CW-1:0] tb_len_nxt;
    logic          frame_done_nxt;

    assign sym_inc  = sym_cnt + CW'(1);
    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ACS;
            S_ACS:   state_nxt = S_CHK;
            S_CHK:   state_nxt = ((sym_inc == BLOCK_LEN) || last_q) ? S_TB : S_IDLE;
            S_TB:    if (tb_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Each output register loads during the state that owns it, so it is visible one cycle later.
    always_comb begin
        bmc_nxt        = bmc_rx_pair;
        last_nxt       = last_q;
        acs_en_nxt     = 1'b0;
        acs_first_nxt  = 1'b0;
        surv_wr_en_nxt = 1'b0;
        surv_addr_nxt  = surv_wr_addr;
        pm_norm_nxt    = 1'b0;
        tb_start_nxt   = 1'b0;
        tb_addr_nxt    = tb_addr;
        tb_len_nxt     = tb_len;
        frame_done_nxt = 1'b0;
        wr_ptr_nxt     = wr_ptr;
        sym_cnt_nxt    = sym_cnt;
        first_flag_nxt = first_flag;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    bmc_nxt  = in_rx_pair;
                    last_nxt = in_last;
                end
            end
            S_ACS: begin
                acs_en_nxt     = 1'b1;
                acs_first_nxt  = first_flag;
                surv_wr_en_nxt = 1'b1;
                surv_addr_nxt  = wr_ptr;
                first_flag_nxt = 1'b0;
            end
            S_CHK: begin
                wr_ptr_nxt  = wr_ptr + AW'(1);
                sym_cnt_nxt = sym_inc;
                pm_norm_nxt = pm_msb_any;
                if ((sym_inc == BLOCK_LEN) || last_q) begin
                    tb_start_nxt = 1'b1;
                    tb_addr_nxt  = wr_ptr;
                    tb_len_nxt   = sym_inc;
                end
            end
            S_TB: begin
                if (tb_done) begin
                    sym_cnt_nxt = '0;
                    if (last_q) begin
                        frame_done_nxt = 1'b1;
                        first_flag_nxt = 1'b1;
                        wr_ptr_nxt     = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmc_rx_pair  <= '0;
            last_q       <= 1'b0;
            acs_en       <= 1'b0;
            acs_first    <= 1'b0;
            surv_wr_en   <= 1'b0;
            surv_wr_addr <= '0;
            pm_norm      <= 1'b0;
            tb_start     <= 1'b0;
            tb_addr      <= '0;
            tb_len       <= '0;
            frame_done   <= 1'b0;
            wr_ptr       <= '0;
            sym_cnt      <= '0;
            first_flag   <= 1'b1;
        end else begin
            bmc_rx_pair  <= bmc_nxt;
            last_q       <= last_nxt;
            acs_en       <= acs_en_nxt;
            acs_first    <= acs_first_nxt;
            surv_wr_en   <= surv_wr_en_nxt;
            surv_wr_addr <= surv_addr_nxt;
            pm_norm      <= pm_norm_nxt;
            tb_start     <= tb_start_nxt;
            tb_addr      <= tb_addr_nxt;
            tb_len       <= tb_len_nxt;
            frame_done   <= frame_done_nxt;
            wr_ptr       <= wr_ptr_nxt;
            sym_cnt      <= sym_cnt_nxt;
            first_flag   <= first_flag_nxt;
        end
    end

`ifdef VITERBI_NORM_CNT_EN
    // pm_norm and frame_done can never coincide: at least one S_TB cycle separates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_cnt <= '0;
        end else if (frame_done) begin
            norm_cnt <= '0;
        end else if (pm_norm && (norm_cnt != 16'hFFFF)) begin
            norm_cnt <= norm_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl with TB_DEPTH=4: directed vector table, reset corner case, randomized frames vs model.
module tb_viterbi_ctrl;

    localparam int TBD  = 4;
    localparam int AW   = 3;
    localparam int CW   = 3;
    localparam int RING = 2 * TBD;
    localparam int NV   = 18;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic [1:0]    in_rx_pair = 2'b00;
    logic          in_last    = 1'b0;
    logic [1:0]    bmc_rx_pair;
    logic          acs_en;
    logic          acs_first;
    logic          pm_msb_any = 1'b0;
    logic          pm_norm;
    logic          surv_wr_en;
    logic [AW-1:0] surv_wr_addr;
    logic          tb_start;
    logic [AW-1:0] tb_addr;
    logic [CW-1:0] tb_len;
    logic          tb_done    = 1'b0;
    logic          frame_done;
`ifdef VITERBI_NORM_CNT_EN
    logic [15:0]   norm_cnt;
`endif

    viterbi_ctrl #(.TB_DEPTH(TBD), .AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rx_pair   (in_rx_pair),
        .in_last      (in_last),
        .bmc_rx_pair  (bmc_rx_pair),
        .acs_en       (acs_en),
        .acs_first    (acs_first),
        .pm_msb_any   (pm_msb_any),
        .pm_norm      (pm_norm),
        .surv_wr_en   (surv_wr_en),
        .surv_wr_addr (surv_wr_addr),
        .tb_start     (tb_start),
        .tb_addr      (tb_addr),
        .tb_len       (tb_len),
        .tb_done      (tb_done),
        .frame_done   (frame_done)
`ifdef VITERBI_NORM_CNT_EN
        ,
        .norm_cnt     (norm_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    pair;
        logic          last;
        logic          msb;
        logic          first;
        logic [AW-1:0] addr;
        logic          tb;
        logic [AW-1:0] tb_addr;
        logic [CW-1:0] tb_len;
    } vec_t;

    typedef struct packed {
        logic [1:0]    pair;
        logic          first;
        logic [AW-1:0] addr;
    } acs_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] len;
    } tb_exp_t;

    vec_t     vt [NV];
    acs_exp_t exp_acs [$];
    tb_exp_t  exp_tb [$];

    int checks = 0, failures = 0;
    int exp_norm = 0, obs_norm = 0, exp_frames = 0, obs_frames = 0;
    int frame_pos = 0;
    int gap = 0, resp_d = 0, wait_n = 0, r_idle = 0;
    bit tb_auto = 1'b1, rand_delay = 1'b0, strict_gap = 1'b1;
    bit seen_acs = 1'b0, tb_since = 1'b0, tb_active = 1'b0;
    logic [AW-1:0] held_addr;
    logic [CW-1:0] held_len;
    logic [1:0]    r_pair;
    logic          r_last, r_msb;
    acs_exp_t      ea;
    tb_exp_t       et;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expectations follow directly from the position of a symbol in its frame.
    task automatic model_push(input logic [1:0] pair, input logic last, input logic msb);
        exp_acs.push_back('{pair: pair, first: (frame_pos == 0), addr: AW'(frame_pos % RING)});
        if (msb) exp_norm++;
        if (((frame_pos % TBD) == TBD - 1) || last)
            exp_tb.push_back('{addr: AW'(frame_pos % RING), len: CW'((frame_pos % TBD) + 1)});
        if (last) begin
            exp_frames++;
            frame_pos = 0;
        end else begin
            frame_pos++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the symbol's check cycle.
    task automatic send(input logic [1:0] pair, input logic last, input logic msb, input int idle);
        int n;
        if (idle > 0) begin
            in_valid = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid   = 1'b1;
        in_rx_pair = pair;
        in_last    = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            pm_msb_any = msb;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            pm_msb_any = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 300 && !(exp_acs.size() == 0 && exp_tb.size() == 0 && in_ready)) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_drain_timeout"}, 32'(n < 300), 32'd1);
        chk({name, "_acs_left"}, 32'(exp_acs.size()), 32'd0);
        chk({name, "_tb_left"}, 32'(exp_tb.size()), 32'd0);
        chk({name, "_pm_norm_count"}, 32'(obs_norm), 32'(exp_norm));
        chk({name, "_frame_done_count"}, 32'(obs_frames), 32'(exp_frames));
    endtask

    // Monitor: samples DUT outputs 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                seen_acs  = 1'b0;
                tb_active = 1'b0;
                gap       = 0;
            end else begin
                gap++;
                if (acs_en) begin
                    chk("acs_with_wr_en", 32'(surv_wr_en), 32'd1);
                    chk("ready_low_in_chk", 32'(in_ready), 32'd0);
                    if (exp_acs.size() == 0) begin
                        chk("acs_unexpected_pulse", 32'(acs_en), 32'd0);
                    end else begin
                        ea = exp_acs.pop_front();
                        chk("bmc_rx_pair", 32'(bmc_rx_pair), 32'(ea.pair));
                        chk("acs_first", 32'(acs_first), 32'(ea.first));
                        chk("surv_wr_addr", 32'(surv_wr_addr), 32'(ea.addr));
                    end
                    if (seen_acs) begin
                        chk("accept_gap_min", 32'(gap >= 3), 32'd1);
                        if (strict_gap && !tb_since) chk("accept_gap_exact", 32'(gap), 32'd3);
                    end
                    seen_acs = 1'b1;
                    tb_since = 1'b0;
                    gap      = 0;
                end else begin
                    chk("wr_en_without_acs", 32'(surv_wr_en), 32'd0);
                end
                if (tb_start) begin
                    chk("ready_low_in_tb", 32'(in_ready), 32'd0);
                    if (exp_tb.size() == 0) begin
                        chk("tb_start_unexpected", 32'(tb_start), 32'd0);
                    end else begin
                        et = exp_tb.pop_front();
                        chk("tb_addr", 32'(tb_addr), 32'(et.addr));
                        chk("tb_len", 32'(tb_len), 32'(et.len));
                    end
                    held_addr = tb_addr;
                    held_len  = tb_len;
                    tb_active = 1'b1;
                    tb_since  = 1'b1;
                end
                if (tb_done && tb_active) begin
                    chk("tb_addr_hold", 32'(tb_addr), 32'(held_addr));
                    chk("tb_len_hold", 32'(tb_len), 32'(held_len));
                    tb_active = 1'b0;
                end
                if (pm_norm) obs_norm++;
                if (frame_done) begin
                    obs_frames++;
                    chk("frame_done_follows_tb_done", 32'(tb_done), 32'd1);
                end
            end
        end
    end

    // Traceback responder: tb_done for one cycle, 0..3 cycles after tb_start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tb_start && tb_auto && rst_n) begin
                resp_d = rand_delay ? int'($urandom_range(0, 3)) : 0;
                repeat (resp_d) @(posedge clk);
                @(negedge clk);
                tb_done = 1'b1;
                @(negedge clk);
                tb_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            pair   last  msb   first addr  tb    tbaddr tblen
        vt[0]  = '{2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0};
        vt[1]  = '{2'b11, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 3'd0};
        vt[2]  = '{2'b01, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 3'd0};
        vt[3]  = '{2'b10, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 3'd4};
        vt[4]  = '{2'b11, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 3'd1};
        vt[5]  = '{2'b01, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0};
        vt[6]  = '{2'b10, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 3'd0, 3'd0};
        vt[7]  = '{2'b11, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 3'd0};
        vt[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 3'd4};
        vt[9]  = '{2'b01, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 3'd0, 3'd0};
        vt[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 3'd0};
        vt[11] = '{2'b11, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 3'd0, 3'd0};
        vt[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 3'd7, 3'd4};
        vt[13] = '{2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0};
        vt[14] = '{2'b10, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 3'd0};
        vt[15] = '{2'b11, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 3'd0};
        vt[16] = '{2'b00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 3'd4};
        vt[17] = '{2'b10, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 3'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_acs_en", 32'(acs_en), 32'd0);
        chk("reset_acs_first", 32'(acs_first), 32'd0);
        chk("reset_surv_wr_en", 32'(surv_wr_en), 32'd0);
        chk("reset_surv_wr_addr", 32'(surv_wr_addr), 32'd0);
        chk("reset_pm_norm", 32'(pm_norm), 32'd0);
        chk("reset_tb_start", 32'(tb_start), 32'd0);
        chk("reset_tb_addr", 32'(tb_addr), 32'd0);
        chk("reset_tb_len", 32'(tb_len), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_bmc_rx_pair", 32'(bmc_rx_pair), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, in_valid held high throughout, immediate tb_done.
        strict_gap = 1'b1;
        rand_delay = 1'b0;
        tb_auto    = 1'b1;
        for (int i = 0; i < NV; i++) begin
            exp_acs.push_back('{pair: vt[i].pair, first: vt[i].first, addr: vt[i].addr});
            if (vt[i].tb) exp_tb.push_back('{addr: vt[i].tb_addr, len: vt[i].tb_len});
            if (vt[i].msb) exp_norm++;
            if (vt[i].last) exp_frames++;
            send(vt[i].pair, vt[i].last, vt[i].msb, 0);
        end
        in_valid = 1'b0;
        drain("table");

        // Reset while waiting on traceback: the frame is discarded.
        strict_gap = 1'b0;
        tb_auto    = 1'b0;
        model_push(2'b01, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0, 0);
        model_push(2'b10, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0, 0);
        model_push(2'b11, 1'b1, 1'b0);
        send(2'b11, 1'b1, 1'b0, 0);
        in_valid = 1'b0;
        wait_n = 0;
        while (exp_tb.size() != 0 && wait_n < 50) begin
            @(posedge clk);
            #2;
            wait_n++;
        end
        chk("rst_test_tb_start_seen", 32'(exp_tb.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        frame_pos = 0;
        exp_frames--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_test_in_ready", 32'(in_ready), 32'd1);
        chk("rst_test_tb_addr_cleared", 32'(tb_addr), 32'd0);
        @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_test_no_frame_done", 32'(obs_frames), 32'(exp_frames));
        chk("rst_test_still_idle", 32'(in_ready), 32'd1);
        tb_auto = 1'b1;
        model_push(2'b01, 1'b1, 1'b1);
        send(2'b01, 1'b1, 1'b1, 0);
        in_valid = 1'b0;
        drain("reset");

        // Randomized frames with random idle gaps and traceback delays.
        rand_delay = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r_pair = 2'($urandom_range(0, 3));
            r_last = ($urandom_range(0, 7) == 0);
            r_msb  = ($urandom_range(0, 3) == 0);
            r_idle = int'($urandom_range(0, 2));
            if (i == 299) r_last = 1'b1;
            model_push(r_pair, r_last, r_msb);
            send(r_pair, r_last, r_msb, r_idle);
        end
        in_valid = 1'b0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
